// File: rtl/audio_tdm_driver.sv
// Serial audio output: frame FIFO feeding an I2S / left-justified / TDM serialiser.
// BCK, LRCK/FS and DATA are all derived from AUDIO_CLK; DATA/LRCK change only on BCK falls.
module audio_tdm_driver #(
    parameter int CHANNELS   = 2,
    parameter int SAMPLE_W   = 24,
    parameter int SLOT_W     = 32,
    parameter int BCK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             AUDIO_CLK,
    input  logic                             iRST_N,
    input  logic [1:0]                       i_mode,
    input  logic [CHANNELS*SAMPLE_W-1:0]     i_frame_data,
    input  logic                             i_frame_valid,
    output logic                             o_frame_ready,
    output logic                             oAUD_BCK,
    output logic                             oAUD_LRCK,
    output logic                             oAUD_DATA,
    output logic                             o_underrun,
    input  logic                             i_clr_underrun,
    output logic [$clog2(FIFO_DEPTH):0]      o_fifo_level
);

    localparam int NB = CHANNELS * SLOT_W;
    localparam int FW = CHANNELS * SAMPLE_W;
    localparam int BW = $clog2(NB);
    localparam int DW = $clog2(BCK_DIV);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        MODE_I2S  = 2'd0,
        MODE_LJ   = 2'd1,
        MODE_TDM  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    logic [DW-1:0] div_q, div_d;
    logic          fall_evt, bck_d;
    logic [BW-1:0] b_q, b_d, d_d;
    mode_e         mode_q, mode_d, mode_eff;
    logic [FW-1:0] frame_q, frame_d;
    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          push, pop, load, lrck_d, data_d;

    assign o_frame_ready = (level != LW'(FIFO_DEPTH));
    assign o_fifo_level  = level;
    assign push          = i_frame_valid && o_frame_ready;

    always_comb begin
        fall_evt = (div_q == DW'(BCK_DIV - 1));
        div_d    = fall_evt ? '0 : div_q + 1'b1;
        bck_d    = (div_d >= DW'(BCK_DIV / 2));
        b_d      = b_q;
        mode_d   = mode_q;
        if (fall_evt) begin
            b_d = (b_q == BW'(NB - 1)) ? '0 : b_q + 1'b1;
            // A new mode only ever starts on a frame boundary.
            if (b_d == '0)
                mode_d = mode_e'(i_mode);
        end
        mode_eff = (mode_d == MODE_RSVD) ? MODE_I2S : mode_d;
        if (mode_eff == MODE_LJ)
            d_d = b_d;
        else
            d_d = (b_d == '0) ? BW'(NB - 1) : b_d - 1'b1;
        if (mode_eff == MODE_TDM)
            lrck_d = (b_d == BW'(NB - 1));
        else
            lrck_d = (b_d >= BW'(NB / 2));
        load    = fall_evt && (d_d == '0);
        pop     = load && (level != '0);
        frame_d = frame_q;
        if (load)
            frame_d = pop ? mem[rd_ptr] : '0;
        // Padding bits beyond SAMPLE_W in each slot stay 0.
        data_d = 1'b0;
        for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < SAMPLE_W; k++)
                if (d_d == BW'(c * SLOT_W + k))
                    data_d = frame_d[c * SAMPLE_W + SAMPLE_W - 1 - k];
    end

    always_ff @(posedge AUDIO_CLK) begin
        if (push)
            mem[wr_ptr] <= i_frame_data;
    end

    always_ff @(posedge AUDIO_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            div_q      <= '0;
            b_q        <= '0;
            mode_q     <= MODE_I2S;
            frame_q    <= '0;
            oAUD_BCK   <= 1'b0;
            oAUD_LRCK  <= 1'b0;
            oAUD_DATA  <= 1'b0;
            o_underrun <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
        end else begin
            div_q    <= div_d;
            oAUD_BCK <= bck_d;
            if (fall_evt) begin
                b_q       <= b_d;
                mode_q    <= mode_d;
                frame_q   <= frame_d;
                oAUD_LRCK <= lrck_d;
                oAUD_DATA <= data_d;
            end
            if (load && (level == '0))
                o_underrun <= 1'b1;
            else if (i_clr_underrun)
                o_underrun <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_tdm_driver.sv
// Bench for audio_tdm_driver: stereo instance checked per cycle against a frame/bit-stream
// model, plus a 4-channel instance checked on BCK rising edges in TDM mode.
module tb_audio_tdm_driver;

    logic AUDIO_CLK = 1'b0;
    logic rst_n;
    always #5 AUDIO_CLK = ~AUDIO_CLK;

    // Stereo instance (I2S / LJ / underrun / FIFO).
    logic [1:0]  mode_a;
    logic [47:0] fd_a;
    logic        fv_a, clr_a, ready_a, bck_a, lrck_a, data_a, under_a;
    logic [2:0]  level_a;

    // Four-channel instance (TDM).
    logic [1:0]  mode_b;
    logic [95:0] fd_b;
    logic        fv_b, clr_b, ready_b, bck_b, lrck_b, data_b, under_b;
    logic [2:0]  level_b;

    int n_cmp = 0;
    int n_fail = 0;

    audio_tdm_driver #(.CHANNELS(2), .SAMPLE_W(24), .SLOT_W(32), .BCK_DIV(4), .FIFO_DEPTH(4)) dut (
        .AUDIO_CLK(AUDIO_CLK), .iRST_N(rst_n), .i_mode(mode_a), .i_frame_data(fd_a),
        .i_frame_valid(fv_a), .o_frame_ready(ready_a), .oAUD_BCK(bck_a), .oAUD_LRCK(lrck_a),
        .oAUD_DATA(data_a), .o_underrun(under_a), .i_clr_underrun(clr_a), .o_fifo_level(level_a)
    );

    audio_tdm_driver #(.CHANNELS(4), .SAMPLE_W(24), .SLOT_W(32), .BCK_DIV(4), .FIFO_DEPTH(4)) dut_tdm (
        .AUDIO_CLK(AUDIO_CLK), .iRST_N(rst_n), .i_mode(mode_b), .i_frame_data(fd_b),
        .i_frame_valid(fv_b), .o_frame_ready(ready_b), .oAUD_BCK(bck_b), .oAUD_LRCK(lrck_b),
        .oAUD_DATA(data_b), .o_underrun(under_b), .i_clr_underrun(clr_b), .o_fifo_level(level_b)
    );

    wire [7:0] obs_a = {bck_a, lrck_a, data_a, ready_a, under_a, level_a};

    // Reference model of the stereo instance: queued frames, and the serial bit stream
    // of the frame currently being played (slot 0 first, MSB first, zero padding).
    logic [47:0] exp_q[$];
    logic        sq[$];
    int   m_div = 0, m_b = 0, m_mode = 0;
    logic m_bck = 0, m_lrck = 0, m_data = 0, m_under = 0;

    function automatic logic [7:0] exp_a();
        return {m_bck, m_lrck, m_data, exp_q.size() != 4, m_under, 3'(exp_q.size())};
    endfunction

    task automatic model_step();
        logic        acc, set;
        logic [47:0] fr;
        int          eff;
        acc = fv_a && (exp_q.size() < 4);
        set = 1'b0;
        m_div = (m_div + 1) % 4;
        m_bck = (m_div >= 2);
        if (m_div == 0) begin
            m_b = (m_b + 1) % 64;
            if (m_b == 0) m_mode = int'(mode_a);
            eff = (m_mode == 3) ? 0 : m_mode;
            m_lrck = (eff == 2) ? (m_b == 63) : (m_b >= 32);
            if ((eff == 1) ? (m_b == 0) : (m_b == 1)) begin
                sq.delete();
                if (exp_q.size() > 0) fr = exp_q.pop_front();
                else begin fr = '0; set = 1'b1; end
                for (int s = 0; s < 2; s++)
                    for (int p = 0; p < 32; p++)
                        sq.push_back((p < 24) ? fr[s * 24 + 23 - p] : 1'b0);
            end
            m_data = (sq.size() > 0) ? sq.pop_front() : 1'b0;
        end
        if (set) m_under = 1'b1;
        else if (clr_a) m_under = 1'b0;
        if (acc) exp_q.push_back(fd_a);
    endtask

    initial begin
        forever begin
            @(posedge AUDIO_CLK or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete(); sq.delete();
                m_div = 0; m_b = 0; m_mode = 0;
                m_bck = 0; m_lrck = 0; m_data = 0; m_under = 0;
            end else begin
                model_step();
            end
        end
    end

    task automatic do_reset(input logic [1:0] m);
        rst_n = 1'b0;
        mode_a = m; mode_b = 2'd2;
        fv_a = 1'b0; clr_a = 1'b0; fd_a = '0;
        fv_b = 1'b0; clr_b = 1'b0; fd_b = '0;
        repeat (3) @(negedge AUDIO_CLK);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(2'd0);
        for (int c = 1; c <= 162; c++) begin
            fv_a = (c <= 4);
            fd_a = {24'($urandom()), 24'($urandom())};
            @(negedge AUDIO_CLK);
            n_cmp++;
            if (obs_a !== exp_a()) begin
                n_fail++;
                $display("FAIL reset_run c=%0d got=%b exp=%b", c, obs_a, exp_a());
            end
        end
        fv_a = 1'b0;
        n_cmp++;
        if (level_a !== 3'd3) begin
            n_fail++;
            $display("FAIL reset_prelevel got=%0d exp=3", level_a);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bck_a, lrck_a, data_a, under_a} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=0000", {bck_a, lrck_a, data_a, under_a});
        end
        n_cmp++;
        if ({ready_a, level_a} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_fifo got=%b exp=1000", {ready_a, level_a});
        end
        @(negedge AUDIO_CLK);
    endtask

    task automatic test_framing(input logic [1:0] m, input int cycles);
        do_reset(m);
        for (int c = 1; c <= cycles; c++) begin
            if (c == 1) begin
                fv_a = 1'b1;
                fd_a = {24'h7FFFFE, 24'h800001};
            end else begin
                fv_a = ($urandom_range(0, 3) == 0);
                fd_a = {24'($urandom()), 24'($urandom())};
            end
            @(negedge AUDIO_CLK);
            n_cmp++;
            if (obs_a !== exp_a()) begin
                n_fail++;
                $display("FAIL framing_mode%0d c=%0d got=%b exp=%b", m, c, obs_a, exp_a());
            end
        end
        fv_a = 1'b0;
    endtask

    task automatic test_underrun();
        do_reset(2'd0);
        for (int c = 1; c <= 300; c++) begin
            clr_a = (c == 20 || c == 260);
            @(negedge AUDIO_CLK);
            n_cmp++;
            if (obs_a !== exp_a()) begin
                n_fail++;
                $display("FAIL underrun_run c=%0d got=%b exp=%b", c, obs_a, exp_a());
            end
            if (c == 10 || c == 20 || c == 259 || c == 260) begin
                n_cmp++;
                if (under_a !== ((c == 10 || c == 260) ? 1'b1 : 1'b0)) begin
                    n_fail++;
                    $display("FAIL underrun_flag c=%0d got=%b exp=%b", c, under_a,
                             (c == 10 || c == 260));
                end
            end
        end
        clr_a = 1'b0;
    endtask

    task automatic test_fifo_full();
        do_reset(2'd0);
        for (int c = 1; c <= 1400; c++) begin
            fv_a = (c >= 10 && c <= 14);
            fd_a = {24'($urandom()), 24'($urandom())};
            @(negedge AUDIO_CLK);
            n_cmp++;
            if (obs_a !== exp_a()) begin
                n_fail++;
                $display("FAIL full_run c=%0d got=%b exp=%b", c, obs_a, exp_a());
            end
            if (c == 14 || c == 260) begin
                n_cmp++;
                if ({ready_a, level_a} !== ((c == 14) ? 4'b0100 : 4'b1011)) begin
                    n_fail++;
                    $display("FAIL full_level c=%0d got=%b exp=%b", c, {ready_a, level_a},
                             (c == 14) ? 4'b0100 : 4'b1011);
                end
            end
        end
        fv_a = 1'b0;
    endtask

    task automatic test_tdm();
        logic [23:0] word;
        logic        prev, el, ed;
        int          k, b, d, f, p;
        word = 24'hABCDEF;
        do_reset(2'd2);
        k = 0;
        prev = 1'b0;
        for (int c = 1; c <= 1200 && k <= 260; c++) begin
            fv_b = (c <= 2);
            fd_b = {word, word, word, word};
            @(negedge AUDIO_CLK);
            if (bck_b && !prev) begin
                b = k % 128;
                // Mode register still holds I2S until the first frame boundary.
                el = (k < 128) ? (b >= 64) : (b == 127);
                ed = 1'b0;
                if (k > 0) begin
                    f = (k - 1) / 128;
                    d = (k - 1) % 128;
                    p = d % 32;
                    if (f < 2 && p < 24) ed = word[23 - p];
                end
                n_cmp++;
                if ({lrck_b, data_b} !== {el, ed}) begin
                    n_fail++;
                    $display("FAIL tdm_bit k=%0d got=%b exp=%b", k, {lrck_b, data_b}, {el, ed});
                end
                k++;
            end
            prev = bck_b;
        end
        fv_b = 1'b0;
        n_cmp++;
        if (k <= 260) begin
            n_fail++;
            $display("FAIL tdm_timeout got=%0d exp=261 BCK rises", k);
        end
        n_cmp++;
        if ({under_b, level_b} !== 4'b1000) begin
            n_fail++;
            $display("FAIL tdm_end got=%b exp=1000", {under_b, level_b});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mode_a = 2'd0; mode_b = 2'd2;
        fv_a = 1'b0; clr_a = 1'b0; fd_a = '0;
        fv_b = 1'b0; clr_b = 1'b0; fd_b = '0;
        test_reset();
        test_framing(2'd0, 1100);
        test_framing(2'd1, 1100);
        test_underrun();
        test_fifo_full();
        test_tdm();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
